iterative_control_unit: RTL and testbench

- Moore-style ASM control unit that sequences a multiply-by-repeated-addition datapath (A := in1, B := in2, R := 0, then R := R + A and B := B - 1 until B == 0).
- Sits beside the datapath in the top level.
- Drives the datapath's register-load enables and reads back its zero flag.
- Exposes a start/done handshake and an iteration count to the surrounding system.

---
 rtl/iterative_control_unit_pkg.sv | 14 +
 rtl/iterative_control_unit_iter_counter.sv | 36 +++
 rtl/iterative_control_unit.sv | 130 +++++++++++++
 tb/tb_iterative_control_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/iterative_control_unit_pkg.sv
// Shared types for the iterative multiply control unit: state encoding and default word width.
package iterative_control_unit_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/iterative_control_unit_iter_counter.sv
// Iteration counter: synchronous clear wins over increment; wraps modulo 2^CNT_W.
module iter_counter
    import iterative_control_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/iterative_control_unit.sv
// Moore control unit sequencing a repeated-addition multiplier datapath.
// Optional iteration timeout compiled in with ITER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// LOAD  | load A/B, clear R, clear count and err
// CHECK | test datapath b_zero flag
// ACCUM | R += A, B -= 1, count++
// DONE  | one-cycle completion pulse
module iterative_control_unit
    import iterative_control_unit_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_ITER = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             b_zero,
    output logic             ld_ab,
    output logic             clr_r,
    output logic             ld_r,
    output logic             dec_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
);

    state_t state_q;
    state_t state_d;

    if (MAX_ITER < 1) begin : g_max_iter_chk
        $error("MAX_ITER must be positive");
    end

`ifdef ITER_TIMEOUT_EN
    logic err_q;
    logic err_d;
`endif

    always_comb begin
        state_d = state_q;
        ld_ab   = 1'b0;
        clr_r   = 1'b0;
        ld_r    = 1'b0;
        dec_b   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef ITER_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_ab   = 1'b1;
                clr_r   = 1'b1;
                busy    = 1'b1;
                state_d = CHECK;
`ifdef ITER_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            CHECK: begin
                busy = 1'b1;
                if (b_zero) begin
                    state_d = DONE;
`ifdef ITER_TIMEOUT_EN
                end else if (iter_count == CNT_W'(MAX_ITER)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
`endif
                end else begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                ld_r    = 1'b1;
                dec_b   = 1'b1;
                busy    = 1'b1;
                state_d = CHECK;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ITER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Counter clears on the LOAD decode and counts each ACCUM cycle.
    iter_counter #(
        .CNT_W(CNT_W)
    ) u_iter_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ld_ab),
        .inc_i  (ld_r),
        .count_o(iter_count)
    );

endmodule

// File: tb/tb_iterative_control_unit.sv
// Scoreboard bench for iterative_control_unit with a behavioural datapath and product model.
module tb_iterative_control_unit;
    import iterative_control_unit_pkg::*;

    localparam int W    = CNT_W_DEF;
    localparam int MAXI = 4;

    typedef struct {
        logic [W-1:0] iter;
        logic [W-1:0] r;
        int           cyc;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         b_zero;
    logic         ld_ab, clr_r, ld_r, dec_b, busy, done, err;
    logic [W-1:0] iter_count;

    logic [W-1:0] in1 = '0, in2 = '0;
    logic [W-1:0] a_q = '0, b_q = '0, r_q = '0;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    iterative_control_unit #(
        .CNT_W   (W),
        .MAX_ITER(MAXI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .b_zero    (b_zero),
        .ld_ab     (ld_ab),
        .clr_r     (clr_r),
        .ld_r      (ld_r),
        .dec_b     (dec_b),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .iter_count(iter_count)
    );

    // Datapath the control unit drives.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_ab) begin
            a_q <= in1;
            b_q <= in2;
        end
        if (clr_r) r_q <= '0;
        if (ld_r)  r_q <= r_q + a_q;
        if (dec_b) b_q <= b_q - 1'b1;
    end
    assign b_zero = (b_q == '0);

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: product by plain multiplication, iteration count, done cycle relative to LOAD.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, int t_load);
        exp_t e;
        int   n;
        n     = int'(b);
        e.err = 1'b0;
`ifdef ITER_TIMEOUT_EN
        if (n > MAXI) begin
            n     = MAXI;
            e.err = 1'b1;
        end
`endif
        e.iter = W'(n);
        e.r    = W'(a * W'(n));
        e.cyc  = t_load + 2 * n + 2;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("ld_r_eq_dec_b", ld_r, dec_b);
            chk("ld_ab_eq_clr_r", ld_ab, clr_r);
            if (done) begin
                chk("done_excl", {busy, ld_ab, clr_r, ld_r, dec_b}, 64'd0);
                done_seen++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("iter_count", iter_count, e.iter);
                    chk("product_r", r_q, e.r);
                    chk("done_cycle", cyc, e.cyc);
                    chk("err", err, e.err);
                end
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int t_load);
        in1 = a;
        in2 = b;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk); #1;
        chk("load_after_start", {ld_ab, clr_r, busy}, 64'h7);
        t_load = cyc;
        sb.push_back(model(a, b, t_load));
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        for (int i = 0; i < limit && done_seen < target; i++) begin
            @(negedge clk); #1;
        end
        if (done_seen < target) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got %0d dones expected %0d", done_seen, target);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        int t;
        int target;
        target = done_seen + 1;
        start_op(a, b, t);
        if (poke && b >= 1) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(target, 2 * int'(b) + 16);
    endtask

    initial begin
        int t1, t2, d0, target;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {ld_ab, clr_r, ld_r, dec_b, busy, done, err}, 64'd0);
        chk("reset_iter", iter_count, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outputs", {ld_ab, clr_r, ld_r, dec_b, busy, done, err}, 64'd0);

        run_op(5, 3, 1'b0);
        run_op(9, 0, 1'b0);
        run_op(7, 3, 1'b1);
        run_op(6, 9, 1'b0);
        run_op(2, 4, 1'b0);

        // Back-to-back with start held high.
        in1 = 3;
        in2 = 2;
        target = done_seen + 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk); #1;
        chk("b2b_load1", ld_ab, 1'b1);
        t1 = cyc;
        sb.push_back(model(3, 2, t1));
        @(negedge clk);
        in1 = 11;
        in2 = 1;
        t2 = -1;
        for (int i = 0; i < 20 && t2 < 0; i++) begin
            @(negedge clk); #1;
            if (ld_ab) t2 = cyc;
        end
        start = 1'b0;
        chk("b2b_load2_cycle", t2, t1 + 2 * 2 + 4);
        chk("b2b_first_done", done_seen, target);
        sb.push_back(model(11, 1, t2));
        @(negedge clk); #1;
        chk("b2b_iter_cleared", iter_count, 64'd0);
        wait_done(target + 1, 20);

        // Reset in the middle of an N=3 operation.
        in1 = 4;
        in2 = 3;
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {ld_ab, clr_r, ld_r, dec_b, busy, done, err}, 64'd0);
        chk("rst_mid_iter", iter_count, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("rst_mid_quiet", {ld_ab, clr_r, ld_r, dec_b, busy, done}, 64'd0);
        end
        chk("rst_mid_no_done", done_seen, d0);

        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom_range(0, 7));
            run_op(a, b, bit'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        miscompares++;
        $display("FAIL watchdog: got no completion expected finish before 400000");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
